// File: rtl/boundary_pkg.sv
// Shared definitions for the bounding-box record path: the record layout
// produced by boundary_extract and consumed by the box-overlay fusion stage.
// Record layout (43 bits): [42] valid, [41:32] ymax, [31:21] xmax,
//                          [20:11] ymin, [10:0] xmin.
package boundary_pkg;

    localparam int NUM_BOX   = 16;
    localparam int BOX_W     = 43;
    localparam int X_W       = 11;
    localparam int Y_W       = 10;

    localparam int VALID_BIT = 42;
    localparam int YMAX_MSB  = 41;
    localparam int YMAX_LSB  = 32;
    localparam int XMAX_MSB  = 31;
    localparam int XMAX_LSB  = 21;
    localparam int YMIN_MSB  = 20;
    localparam int YMIN_LSB  = 11;
    localparam int XMIN_MSB  = 10;
    localparam int XMIN_LSB  = 0;

    typedef struct packed {
        logic           valid;
        logic [Y_W-1:0] ymax;
        logic [X_W-1:0] xmax;
        logic [Y_W-1:0] ymin;
        logic [X_W-1:0] xmin;
    } box_t;

    function automatic logic [BOX_W-1:0] pack_box(input box_t b);
        logic [BOX_W-1:0] v;
        v                     = '0;
        v[VALID_BIT]          = b.valid;
        v[YMAX_MSB:YMAX_LSB]  = b.ymax;
        v[XMAX_MSB:XMAX_LSB]  = b.xmax;
        v[YMIN_MSB:YMIN_LSB]  = b.ymin;
        v[XMIN_MSB:XMIN_LSB]  = b.xmin;
        return v;
    endfunction

    function automatic box_t unpack_box(input logic [BOX_W-1:0] v);
        box_t b;
        b.valid = v[VALID_BIT];
        b.ymax  = v[YMAX_MSB:YMAX_LSB];
        b.xmax  = v[XMAX_MSB:XMAX_LSB];
        b.ymin  = v[YMIN_MSB:YMIN_LSB];
        b.xmin  = v[XMIN_MSB:XMIN_LSB];
        return b;
    endfunction

endpackage

// File: rtl/boundary_slot.sv
// One working box slot: proximity comparator plus the expand / allocate /
// clear register.
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   i_x, i_y           : current pixel position
//   i_alloc            : load the slot with a 1x1 box at the pixel
//   i_expand           : grow the box to include the pixel
//   i_kill             : discard contents (frame abort); i_alloc wins
//   i_clear            : discard after this cycle's update (frame commit)
//   o_match            : pixel lies within MERGE_DIST of the held box
//   o_box              : registered box
//   o_nxt              : box including this cycle's update, before i_clear
module boundary_slot
    import boundary_pkg::*;
#(
    parameter int MERGE_DIST = 8
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    input  logic [X_W-1:0] i_x,
    input  logic [Y_W-1:0] i_y,
    input  logic           i_alloc,
    input  logic           i_expand,
    input  logic           i_kill,
    input  logic           i_clear,
    output logic           o_match,
    output box_t           o_box,
    output box_t           o_nxt
);

    localparam logic [11:0] MD = 12'(MERGE_DIST);

    box_t        r_box;
    box_t        w_nxt;
    logic [11:0] w_x12, w_y12;

    assign w_x12 = {1'b0, i_x};
    assign w_y12 = {2'b0, i_y};

    // Distance is tested by adding MERGE_DIST on the opposite side, so no
    // subtraction can wrap near the frame origin.
    assign o_match = r_box.valid
                  && (w_x12 + MD >= {1'b0, r_box.xmin})
                  && (w_x12 <= {1'b0, r_box.xmax} + MD)
                  && (w_y12 + MD >= {2'b0, r_box.ymin})
                  && (w_y12 <= {2'b0, r_box.ymax} + MD);

    always_comb begin
        w_nxt = r_box;
        if (i_alloc) begin
            w_nxt.valid = 1'b1;
            w_nxt.xmin  = i_x;
            w_nxt.xmax  = i_x;
            w_nxt.ymin  = i_y;
            w_nxt.ymax  = i_y;
        end else if (i_kill) begin
            w_nxt = '0;
        end else if (i_expand) begin
            if (i_x < r_box.xmin) w_nxt.xmin = i_x;
            if (i_x > r_box.xmax) w_nxt.xmax = i_x;
            if (i_y < r_box.ymin) w_nxt.ymin = i_y;
            if (i_y > r_box.ymax) w_nxt.ymax = i_y;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)   r_box <= '0;
        else if (i_clear) r_box <= '0;
        else              r_box <= w_nxt;
    end

    assign o_box = r_box;
    assign o_nxt = w_nxt;

endmodule

// File: rtl/boundary_extract.sv
// Bounding-box extraction from a 1-bit foreground raster stream.
// Each foreground pixel expands the first nearby box or allocates the first
// free slot; at the last pixel of the frame the size-filtered boxes are
// registered and held until the next commit.
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   pre_wr_en          : pixel valid
//   pre_vs             : frame sync, rising edge restarts the frame
//   bin_pixel          : foreground flag
//   pos_data           : committed box records, one per slot
//   frame_done         : one-cycle pulse when pos_data updates
//   obj_cnt            : number of valid committed records
//   overflow           : a foreground pixel found no slot last frame
module boundary_extract
    import boundary_pkg::*;
#(
    parameter int H_PIXEL    = 1024,
    parameter int V_PIXEL    = 768,
    parameter int MERGE_DIST = 8,
    parameter int MIN_W      = 4,
    parameter int MIN_H      = 4
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst_n,
    input  logic                            pre_wr_en,
    input  logic                            pre_vs,
    input  logic                            bin_pixel,
    output logic [NUM_BOX-1:0][BOX_W-1:0]   pos_data,
    output logic                            frame_done,
    output logic [4:0]                      obj_cnt,
    output logic                            overflow
);

    localparam logic [10:0] X_LAST = 11'(H_PIXEL - 1);
    localparam logic [10:0] Y_LAST = 11'(V_PIXEL - 1);

    logic [10:0]                    r_cnt_x, r_cnt_y;
    logic                           r_vs_d1, r_vs_d2;
    logic                           r_ovf_wip;
    logic [NUM_BOX-1:0][BOX_W-1:0]  r_pos;
    logic                           r_done;
    logic [4:0]                     r_cnt;
    logic                           r_ovf;

    logic                           w_vs_edge;
    logic [10:0]                    w_x, w_y, w_x_nxt, w_y_nxt;
    logic                           w_fg, w_last, w_drop;
    logic [NUM_BOX-1:0]             w_match, w_hit, w_free;
    logic [NUM_BOX-1:0]             w_hit_1h, w_free_1h;
    logic [NUM_BOX-1:0]             w_expand, w_alloc, w_keep;
    logic [NUM_BOX-1:0][BOX_W-1:0]  w_rec;
    logic [4:0]                     w_cnt;
    box_t                           w_box [NUM_BOX];
    box_t                           w_nxt [NUM_BOX];

    // A detected vs edge makes this cycle's pixel (0,0) of a new frame and
    // presents an empty working set to it.
    assign w_vs_edge = r_vs_d1 & ~r_vs_d2;
    assign w_x       = w_vs_edge ? 11'd0 : r_cnt_x;
    assign w_y       = w_vs_edge ? 11'd0 : r_cnt_y;
    assign w_fg      = pre_wr_en & bin_pixel;
    assign w_last    = pre_wr_en && (w_x == X_LAST) && (w_y == Y_LAST);

    assign w_x_nxt = (w_x == X_LAST) ? 11'd0 : w_x + 11'd1;
    assign w_y_nxt = (w_x != X_LAST) ? w_y :
                     (w_y == Y_LAST) ? 11'd0 : w_y + 11'd1;

    // Lowest-index selection: x & -x isolates the least significant one.
    assign w_hit     = w_match & {NUM_BOX{~w_vs_edge}};
    assign w_hit_1h  = w_hit  & (~w_hit  + 1'b1);
    assign w_free_1h = w_free & (~w_free + 1'b1);
    assign w_expand  = w_fg ? w_hit_1h : '0;
    assign w_alloc   = (w_fg && !(|w_hit)) ? w_free_1h : '0;
    assign w_drop    = w_fg && !(|w_hit) && !(|w_free);

    for (genvar g = 0; g < NUM_BOX; g++) begin : g_slot
        logic [11:0] w_wd, w_ht;

        boundary_slot #(.MERGE_DIST(MERGE_DIST)) u_slot (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .i_x       (w_x),
            .i_y       (w_y[Y_W-1:0]),
            .i_alloc   (w_alloc[g]),
            .i_expand  (w_expand[g]),
            .i_kill    (w_vs_edge),
            .i_clear   (w_last),
            .o_match   (w_match[g]),
            .o_box     (w_box[g]),
            .o_nxt     (w_nxt[g])
        );

        assign w_free[g] = ~w_box[g].valid | w_vs_edge;

        // Committed records come from the post-update view so the last
        // pixel of the frame is included in the same cycle it is accepted.
        assign w_wd      = {1'b0, w_nxt[g].xmax} - {1'b0, w_nxt[g].xmin} + 12'd1;
        assign w_ht      = {2'b0, w_nxt[g].ymax} - {2'b0, w_nxt[g].ymin} + 12'd1;
        assign w_keep[g] = w_nxt[g].valid && (w_wd >= 12'(MIN_W)) && (w_ht >= 12'(MIN_H));
        assign w_rec[g]  = w_keep[g] ? pack_box(w_nxt[g]) : '0;
    end

    always_comb begin
        w_cnt = '0;
        for (int k = 0; k < NUM_BOX; k++) w_cnt = w_cnt + 5'(w_keep[k]);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt_x   <= '0;
            r_cnt_y   <= '0;
            r_vs_d1   <= 1'b0;
            r_vs_d2   <= 1'b0;
            r_ovf_wip <= 1'b0;
            r_pos     <= '0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_vs_d1 <= pre_vs;
            r_vs_d2 <= r_vs_d1;
            r_done  <= w_last;
            r_cnt_x <= pre_wr_en ? w_x_nxt : w_x;
            r_cnt_y <= pre_wr_en ? w_y_nxt : w_y;

            if (w_last || w_vs_edge) r_ovf_wip <= 1'b0;
            else if (w_drop)         r_ovf_wip <= 1'b1;

            if (w_last) begin
                r_pos <= w_rec;
                r_cnt <= w_cnt;
                r_ovf <= r_ovf_wip | w_drop;
            end
        end
    end

    assign pos_data   = r_pos;
    assign frame_done = r_done;
    assign obj_cnt    = r_cnt;
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_boundary_extract.sv
module tb_boundary_extract;

    localparam int H  = 64;
    localparam int V  = 48;
    localparam int MD = 8;
    localparam int MW = 4;
    localparam int MH = 4;
    localparam int NB = 16;

    logic                  sys_clk = 1'b0;
    logic                  sys_rst_n = 1'b0;
    logic                  pre_wr_en = 1'b0;
    logic                  pre_vs = 1'b0;
    logic                  bin_pixel = 1'b0;
    logic [NB-1:0][42:0]   pos_data;
    logic                  frame_done;
    logic [4:0]            obj_cnt;
    logic                  overflow;

    boundary_extract #(
        .H_PIXEL(H), .V_PIXEL(V), .MERGE_DIST(MD), .MIN_W(MW), .MIN_H(MH)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .pre_wr_en  (pre_wr_en),
        .pre_vs     (pre_vs),
        .bin_pixel  (bin_pixel),
        .pos_data   (pos_data),
        .frame_done (frame_done),
        .obj_cnt    (obj_cnt),
        .overflow   (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;

    bit bm [H*V];

    // Reference model: box list per slot, frame position, sync history.
    int bv [NB], bx0 [NB], bx1 [NB], by0 [NB], by1 [NB];
    int m_ovf, cx, cy, h1, h2;
    logic [NB-1:0][42:0] e_pos;
    logic                e_fd;
    logic [4:0]          e_cnt;
    logic                e_ovf;

    task automatic m_clear_set();
        for (int k = 0; k < NB; k++) begin
            bv[k] = 0; bx0[k] = 0; bx1[k] = 0; by0[k] = 0; by1[k] = 0;
        end
        m_ovf = 0;
    endtask

    task automatic m_reset();
        m_clear_set();
        cx = 0; cy = 0; h1 = 0; h2 = 0;
        e_pos = '0; e_fd = 1'b0; e_cnt = '0; e_ovf = 1'b0;
    endtask

    task automatic m_pixel(input int x, input int y);
        for (int k = 0; k < NB; k++) begin
            if (bv[k] != 0 && x + MD >= bx0[k] && x <= bx1[k] + MD &&
                y + MD >= by0[k] && y <= by1[k] + MD) begin
                if (x < bx0[k]) bx0[k] = x;
                if (x > bx1[k]) bx1[k] = x;
                if (y < by0[k]) by0[k] = y;
                if (y > by1[k]) by1[k] = y;
                return;
            end
        end
        for (int k = 0; k < NB; k++) begin
            if (bv[k] == 0) begin
                bv[k] = 1; bx0[k] = x; bx1[k] = x; by0[k] = y; by1[k] = y;
                return;
            end
        end
        m_ovf = 1;
    endtask

    task automatic m_commit();
        e_cnt = '0;
        for (int k = 0; k < NB; k++) begin
            if (bv[k] != 0 && bx1[k] - bx0[k] + 1 >= MW && by1[k] - by0[k] + 1 >= MH) begin
                e_pos[k] = {1'b1, by1[k][9:0], bx1[k][10:0], by0[k][9:0], bx0[k][10:0]};
                e_cnt    = e_cnt + 5'd1;
            end else begin
                e_pos[k] = '0;
            end
        end
        e_ovf = (m_ovf != 0);
        e_fd  = 1'b1;
        m_clear_set();
    endtask

    // One clock edge as seen by the frame rules.
    task automatic m_step(input bit en, input bit b, input bit vs);
        bit edge_seen;
        edge_seen = (h1 != 0) && (h2 == 0);
        h2 = h1;
        h1 = vs ? 1 : 0;
        e_fd = 1'b0;
        if (edge_seen) begin
            cx = 0; cy = 0;
            m_clear_set();
        end
        if (en) begin
            if (b) m_pixel(cx, cy);
            if (cx == H-1 && cy == V-1) m_commit();
            if (cx == H-1) begin
                cx = 0;
                cy = (cy == V-1) ? 0 : cy + 1;
            end else begin
                cx = cx + 1;
            end
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_box(input string name, input int k, input logic [42:0] exp);
        checks++;
        if (pos_data[k] !== exp) begin
            errors++;
            $display("FAIL %s slot%0d: got %h expected %h", name, k, pos_data[k], exp);
        end
    endtask

    task automatic chk_pos(input string name, input logic [NB-1:0][42:0] exp);
        checks++;
        if (pos_data !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, pos_data, exp, $time);
        end
    endtask

    // Drive one cycle, advance the model over the edge, compare just after.
    task automatic tick(input bit en, input bit b, input bit vs);
        pre_wr_en = en; bin_pixel = b; pre_vs = vs;
        @(posedge sys_clk);
        m_step(en, b, vs);
        #1;
        chk_int("ctl", int'({frame_done, obj_cnt, overflow}), int'({e_fd, e_cnt, e_ovf}));
        chk_pos("pos", e_pos);
    endtask

    task automatic fill(input int x0, input int y0, input int w, input int h);
        for (int y = y0; y < y0 + h && y < V; y++)
            for (int x = x0; x < x0 + w && x < H; x++)
                bm[y*H + x] = 1'b1;
    endtask

    task automatic build(input int kind);
        for (int i = 0; i < H*V; i++) bm[i] = 1'b0;
        case (kind)
            1: fill(20, 10, 10, 6);
            2: begin fill(2, 2, 6, 6); fill(40, 30, 10, 6); end
            3: begin fill(30, 30, 1, 1); fill(0, 0, 5, 5); end
            4: for (int b = 0; b < 17; b++) fill((b % 6) * 12, (b / 6) * 12, 4, 4);
            5: fill(0, 0, 4, 4);
            6: begin
                int n;
                n = int'($urandom_range(2, 9));
                for (int r = 0; r < n; r++)
                    fill(int'($urandom_range(0, H-1)), int'($urandom_range(0, V-1)),
                         int'($urandom_range(1, 10)), int'($urandom_range(1, 10)));
                n = int'($urandom_range(0, 25));
                for (int r = 0; r < n; r++)
                    bm[$urandom_range(0, H*V-1)] = 1'b1;
            end
            default: ;
        endcase
    endtask

    // Stream the first npix pixels of the bitmap, with random idle gaps.
    task automatic run(input int idle_pct, input int npix);
        for (int i = 0; i < npix; i++) begin
            if (idle_pct > 0 && int'($urandom_range(0, 99)) < idle_pct) begin
                int n;
                n = int'($urandom_range(1, 3));
                for (int j = 0; j < n; j++) tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
            tick(1'b1, bm[i], 1'b0);
        end
    endtask

    initial begin
        m_reset();
        repeat (3) @(posedge sys_clk);
        #1;
        chk_int("reset ctl", int'({frame_done, obj_cnt, overflow}), 0);
        chk_pos("reset pos", '0);
        sys_rst_n = 1'b1;

        // 1: single rectangle, frame_done right after the last pixel
        build(1); run(10, H*V);
        chk_int("t1 done", int'(frame_done), 1);
        chk_box("t1", 0, {1'b1, 10'd15, 11'd29, 10'd10, 11'd20});
        for (int k = 1; k < NB; k++) chk_box("t1 empty", k, '0);
        chk_int("t1 cnt", int'(obj_cnt), 1);
        chk_int("t1 ovf", int'(overflow), 0);

        // 2: two separated rectangles
        build(2); run(10, H*V);
        chk_box("t2", 0, {1'b1, 10'd7, 11'd7, 10'd2, 11'd2});
        chk_box("t2", 1, {1'b1, 10'd35, 11'd49, 10'd30, 11'd40});
        chk_int("t2 cnt", int'(obj_cnt), 2);

        // 3: isolated pixel is filtered, block at the origin
        build(3); run(10, H*V);
        chk_box("t3", 0, {1'b1, 10'd4, 11'd4, 10'd0, 11'd0});
        chk_box("t3 filtered", 1, '0);
        chk_int("t3 cnt", int'(obj_cnt), 1);

        // 4: 17 blocks exhaust the slots, then an empty frame
        build(4); run(0, H*V);
        chk_int("t4 cnt", int'(obj_cnt), 16);
        chk_int("t4 ovf", int'(overflow), 1);
        build(0); run(0, H*V);
        chk_int("t4b cnt", int'(obj_cnt), 0);
        chk_int("t4b ovf", int'(overflow), 0);
        chk_pos("t4b pos", '0);

        // 5: first pixel of the next frame lands in the commit cycle
        build(2); run(0, H*V);
        chk_box("t5 prev", 0, {1'b1, 10'd7, 11'd7, 10'd2, 11'd2});
        build(5); run(0, H*V);
        chk_box("t5", 0, {1'b1, 10'd3, 11'd3, 10'd0, 11'd0});
        chk_int("t5 cnt", int'(obj_cnt), 1);

        // randomized frames
        for (int r = 0; r < 4; r++) begin
            build(6); run(20, H*V);
        end

        // 6: vs abort mid-frame keeps prior outputs, counters restart
        build(5); run(0, H*V);
        build(1); run(0, 16*H);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk_box("t6 held", 0, {1'b1, 10'd3, 11'd3, 10'd0, 11'd0});
        chk_int("t6 held cnt", int'(obj_cnt), 1);
        build(2); run(10, H*V);
        chk_box("t6 restart", 0, {1'b1, 10'd7, 11'd7, 10'd2, 11'd2});
        chk_int("t6 restart cnt", int'(obj_cnt), 2);

        // asynchronous reset mid-frame
        build(1); run(0, 12*H + 5);
        pre_wr_en = 1'b0; bin_pixel = 1'b0; pre_vs = 1'b0;
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk_int("rst ctl", int'({frame_done, obj_cnt, overflow}), 0);
        chk_pos("rst pos", '0);
        m_reset();
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        build(1); run(10, H*V);
        chk_box("post rst", 0, {1'b1, 10'd15, 11'd29, 10'd10, 11'd20});
        chk_int("post rst cnt", int'(obj_cnt), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
